data_memory_pipe: RTL and testbench

DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

---
 rtl/data_memory_pipe.sv | 103 ++++++++++
 tb/tb_data_memory_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_pipe.sv
// Byte-enabled word memory with a 2-entry response FIFO and registered req_ready.
// Optional macro DMEM_RANGE_CHECK_EN flags word indices >= DEPTH with rsp_err instead of wrapping.
module data_memory_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_err_q  [2];

  logic                  push, pop, oob;
  logic [AW-1:0]         mem_idx;
  logic [DATA_WIDTH-1:0] rd_word, push_data;

  assign mem_idx = AW'(req_addr >> LB);

`ifdef DMEM_RANGE_CHECK_EN
  assign oob = |(req_addr >> (LB + AW));
`else
  assign oob = 1'b0;
`endif

  // ready_q keeps req_ready low until the first edge after reset release
  assign req_ready = ready_q && (count_q != 2'd2);
  assign rsp_valid = (count_q != 2'd0);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Read snapshot is taken from the array before this edge's write lands
  assign rd_word   = mem[mem_idx];
  assign push_data = (req_we || oob) ? '0 : rd_word;

  assign rsp_rdata = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign rsp_err   = rsp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= 1'b1;
    end
  end

  // Payload storage carries no reset; visibility is gated by count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_err_q[wr_ptr_q]  <= oob;
    end
  end

  always_ff @(posedge clk) begin
    if (push && req_we && !oob) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) mem[mem_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench for data_memory_pipe: vector table plus backpressure, snapshot and reset sequences.
module tb_data_memory_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One request with rsp_ready=1; response checked right after the accept edge
  task automatic do_req(input string nm, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] er, input logic ee);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    rsp_ready = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({nm, " vld"},   {31'd0, rsp_valid}, 32'd1);
    chk({nm, " rdata"}, rsp_rdata, er);
    chk({nm, " err"},   {31'd0, rsp_err}, {31'd0, ee});
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h13,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h10,   32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[5]  = '{1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[7]  = '{1'b1, 32'h14,   32'h00000000, 4'hF, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 32'h14,   32'hA5A5A5A5, 4'hA, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h14,   32'h0,        4'h0, 32'hA500A500, 1'b0};
    vecs[10] = '{1'b1, 32'h0,    32'h12345678, 4'hF, 32'h0,        1'b0};
`ifdef DMEM_RANGE_CHECK_EN
    vecs[11] = '{1'b0, 32'h4000, 32'h0,        4'h0, 32'h0,        1'b1};
`else
    vecs[11] = '{1'b0, 32'h4000, 32'h0,        4'h0, 32'h12345678, 1'b0};
`endif
    vecs[12] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h12345678, 1'b0};
    vecs[13] = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[14] = '{1'b1, 32'h20,   32'h00000001, 4'hF, 32'h0,        1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", {31'd0, req_ready}, 32'd0);
    chk("rst vld",   {31'd0, rsp_valid}, 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err",   {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel ready pre-edge", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel ready post-edge", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 15; i++)
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err);
    @(posedge clk); #1;
    chk("drain vld", {31'd0, rsp_valid}, 32'd0);

    // Backpressure: three reads with rsp_ready low
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    chk("bp ready1", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("bp head1", rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    req_addr = 32'h20;
    chk("bp ready2", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h0;
    chk("bp ready3", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp stall ready", {31'd0, req_ready}, 32'd0);
    chk("bp stall vld",   {31'd0, rsp_valid}, 32'd1);
    chk("bp stall rdata", rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp resp2", rsp_rdata, 32'h1);
    chk("bp ready after pop", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp resp3", rsp_rdata, 32'h12345678);
    chk("bp resp3 vld", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("bp empty", {31'd0, rsp_valid}, 32'd0);

    // Snapshot: read 0x20 stalled, then overwrite it
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
    @(negedge clk);
    req_we = 1'b1; req_wdata = 32'h2; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    chk("snap ready full", {31'd0, req_ready}, 32'd0);
    chk("snap head", rsp_rdata, 32'h1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("snap wr rsp vld",   {31'd0, rsp_valid}, 32'd1);
    chk("snap wr rsp rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    chk("snap empty", {31'd0, rsp_valid}, 32'd0);
    do_req("snap reread", 1'b0, 32'h20, 32'h0, 4'h0, 32'h2, 1'b0);

    // Reset with two responses queued
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid full vld", {31'd0, rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst vld",   {31'd0, rsp_valid}, 32'd0);
    chk("mid rst ready", {31'd0, req_ready}, 32'd0);
    chk("mid rst rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid rel ready", {31'd0, req_ready}, 32'd1);
    chk("mid rel vld",   {31'd0, rsp_valid}, 32'd0);
    do_req("post rst read", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    do_req("word0 kept",    1'b0, 32'h0,  32'h0, 4'h0, 32'h12345678, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
